// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The optional parity bit is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam int unsigned DefClksPerBit = 868;
    localparam int unsigned DefDataW      = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_t;

    // Ceiling log2 with a floor of one bit, so a terminal count of 1 still has a counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((64'd1 << w) < 64'(value))) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Parallel-side handshake and status bundle of the UART transmitter.
interface uart_tx_fsm_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
);
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_line;
    logic              bit_adv;
    logic              byte_done;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, tx_line, bit_adv, byte_done
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, tx_line, bit_adv, byte_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, holds at zero otherwise.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int unsigned    CntW = clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    // tick is a flop set one edge early so it is high exactly while cnt_q sits at Last.
    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != Last)) begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d = run && (cnt_d == Last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: frame FSM and shift register, 8N1 by default, even parity with
// UART_TX_PARITY_EN defined. bit_adv/byte_done feed the downstream event counters.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned DATA_W       = DefDataW
) (
    input logic          clk,
    input logic          rst,
    uart_tx_fsm_if.slave bus
);
    localparam int unsigned     IdxW    = clog2(DATA_W);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              line_q, line_d;
    logic              busy_q;
    logic              tick;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .run (state_q != StIdle),
        .tick(tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.tx_start) begin
                    shift_d  = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the next state, giving one cycle accept-to-start latency.
        line_d = 1'b1;
        case (state_d)
            StStart: line_d = 1'b0;
            StData:  line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: line_d = parity_q;
`endif
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            line_q   <= line_d;
            busy_q   <= (state_d != StIdle);
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx_line   = line_q;
    assign bus.tx_busy   = busy_q;
    assign bus.bit_adv   = tick;
    assign bus.byte_done = tick && (state_q == StStop);

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm; frames are predicted from the byte value alone.
module tb_uart_tx_fsm;
    localparam int unsigned C = 4;
    localparam int unsigned W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned ParBits = 1;
`else
    localparam int unsigned ParBits = 0;
`endif
    localparam int unsigned FrameBits = W + 2 + ParBits;
    localparam int          FrameCyc  = int'(FrameBits * C);

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_tx_fsm_if #(.DATA_W(W)) bus ();

    uart_tx_fsm #(
        .CLKS_PER_BIT(C),
        .DATA_W      (W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] adv_cnt  = '0;
    int         done_cnt = 0;

    // Stand-ins for the downstream bit and byte event counters.
    always @(posedge clk) begin
        if (bus.bit_adv) adv_cnt <= adv_cnt + 8'd1;
        if (bus.byte_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Serial level of bit slot b of a frame carrying d.
    function automatic logic frame_bit(input logic [W-1:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= int'(W)) return d[b-1];
        if (ParBits == 1 && b == int'(W) + 1) return logic'($countones(d) % 2);
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check_bit({tag, " tx_line"}, bus.tx_line, 1'b1);
        check_bit({tag, " tx_busy"}, bus.tx_busy, 1'b0);
        check_bit({tag, " bit_adv"}, bus.bit_adv, 1'b0);
        check_bit({tag, " byte_done"}, bus.byte_done, 1'b0);
    endtask

    // Called at the negedge of the first frame cycle; returns at the negedge after the frame.
    task automatic expect_frame(input logic [W-1:0] d, input bit hold, input int poke_at,
                                input logic [W-1:0] poke);
        for (int k = 0; k < FrameCyc; k++) begin
            if (k == 0 && !hold) bus.tx_start = 1'b0;
            if (poke_at >= 0 && k == poke_at) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = poke;
            end
            if (poke_at >= 0 && k == poke_at + 1) bus.tx_start = 1'b0;
            check_bit($sformatf("tx_line d=%h k=%0d", d, k), bus.tx_line,
                      frame_bit(d, k / int'(C)));
            check_bit($sformatf("bit_adv k=%0d", k), bus.bit_adv, (k % int'(C)) == int'(C) - 1);
            check_bit($sformatf("byte_done k=%0d", k), bus.byte_done, k == FrameCyc - 1);
            check_bit($sformatf("tx_busy k=%0d", k), bus.tx_busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic start_frame(input logic [W-1:0] d);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [W-1:0] d, input int poke_at, input logic [W-1:0] poke);
        start_frame(d);
        expect_frame(d, 1'b0, poke_at, poke);
        check_idle("after frame");
    endtask

    initial begin
        int         d0;
        logic [7:0] a0;
        logic [7:0] diff;
        int         gap;
        int         poke_at;

        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        repeat (2) @(negedge clk);
        check_idle("in reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("after release");

        d0 = done_cnt;
        send_byte(8'hA5, -1, 8'h00);
        check_int("A5 byte_done count", done_cnt - d0, 1);

        // Back-to-back with tx_start held high; tx_data swapped mid-frame.
        d0 = done_cnt;
        start_frame(8'h00);
        bus.tx_data = 8'hFF;
        expect_frame(8'h00, 1'b1, -1, 8'h00);
        check_idle("b2b gap");
        @(negedge clk);
        expect_frame(8'hFF, 1'b0, -1, 8'h00);
        check_idle("b2b end");
        check_int("b2b byte_done count", done_cnt - d0, 2);

        // Request during DATA must be dropped, not queued.
        send_byte(8'hC3, int'(C) * 3 + 1, 8'h3C);
        @(negedge clk);
        check_idle("no queued frame");

        send_byte(8'h07, -1, 8'h00);
        send_byte(8'h03, -1, 8'h00);

        a0 = adv_cnt;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), -1, 8'h00);
        diff = adv_cnt - a0;
        check_int("bit_adv event count", int'(diff), int'(FrameBits * 3));

        // Asynchronous abort in the middle of the data bits.
        d0 = done_cnt;
        start_frame(8'h5A);
        bus.tx_start = 1'b0;
        repeat (C * 3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_bit("abort tx_line", bus.tx_line, 1'b1);
        check_bit("abort tx_busy", bus.tx_busy, 1'b0);
        check_bit("abort bit_adv", bus.bit_adv, 1'b0);
        @(negedge clk);
        check_idle("held in reset");
        rst = 1'b1;
        for (int k = 0; k < FrameCyc; k++) begin
            @(negedge clk);
            check_bit("post-abort tx_line", bus.tx_line, 1'b1);
            check_bit("post-abort tx_busy", bus.tx_busy, 1'b0);
        end
        check_int("abort byte_done count", done_cnt - d0, 0);

        for (int i = 0; i < 24; i++) begin
            gap     = int'($urandom_range(0, 3));
            poke_at = ($urandom_range(0, 1) == 1) ?
                      int'($urandom_range(C, C * (W + 1) - 2)) : -1;
            send_byte(8'($urandom), poke_at, 8'($urandom));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle("random gap");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- UART transmitter control stage for the processor's serial debug/output path: accepts a parallel byte, serialises it as 8N1 (optionally 8E1) on tx_line.
- Sits directly upstream of the team's parameterised event counter: emits a one-cycle bit_adv pulse per transmitted bit, which drives that counter's enable input; a second pulse, byte_done, feeds the byte-count counter instance.
- Owns baud timing, the shift register and the frame state machine.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- DATA_W, 8, data bits per frame; legal range 5..9.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- tx_start  in  1  request; sampled only in IDLE.
- tx_data  in  DATA_W  byte to send; captured on the accepted tx_start cycle.
- tx_busy  out  1  high from the accept cycle through the last stop-bit cycle.
- tx_line  out  1  serial output; idle high.
- bit_adv  out  1  one-cycle pulse at the end of each transmitted bit (start, data, parity, stop).
- byte_done  out  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_line=1, tx_busy=0, bit_adv=0, byte_done=0, baud counter=0, bit index=0, shift register=0. Release is synchronous to clk; the first active edge after release sees IDLE.
- States: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: tx_line=1. If tx_start=1, latch tx_data into the shift register, clear the baud counter and go to START. tx_busy goes high on the next edge (registered).
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. At CLKS_PER_BIT-1: "bit end", counter wraps to 0, bit_adv=1 for that one cycle.
- Counter width: clog2(CLKS_PER_BIT) bits, computed in the package function; no overflow past the terminal value.
- START: tx_line=0 for CLKS_PER_BIT cycles. On bit end, go to DATA with bit index=0.
- DATA:
  - tx_line = shift[0], LSB first.
  - On bit end, shift right and increment the bit index.
  - When the bit index reaches DATA_W-1 at bit end, go to PARITY (feature on) or STOP.
- STOP: tx_line=1 for CLKS_PER_BIT cycles. On bit end:
  - byte_done=1 and bit_adv=1 in the same cycle;
  - go to IDLE; tx_busy falls on that same edge.
- Frame length: exactly (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity. Latency from accepted tx_start to the start-bit edge on tx_line: 1 cycle.
- Back-to-back frames: tx_start high on the cycle after byte_done is accepted. The line returns to IDLE for exactly 1 cycle (tx_line=1) before the next start bit; no stop-bit truncation.
- tx_start while busy: ignored, with no queueing. The tx_data change mid-frame has no effect, because the shift register is already loaded.
- Reset mid-frame: immediate abort, tx_line=1; no byte_done is issued.
- bit_adv and byte_done are registered outputs, never combinational from tx_start.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP. tx_line = XOR of the latched data (even parity), computed at accept time and held in a flag. The extra bit_adv pulse is counted.
- Undefined: no PARITY state, no parity flag register; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - default CLKS_PER_BIT;
  - clog2 helper function.
- One natural sub-module, uart_baud_gen:
  - holds the parameterised baud counter;
  - inputs: clk, rst, run;
  - output: tick at the terminal count;
  - clears when run=0.
- The FSM and shift register stay in uart_tx_fsm.

Test Plan:
- Reset: assert rst=0 mid-stream -> tx_line=1, tx_busy=0, bit_adv=0 within the same cycle (asynchronous); no byte_done afterwards.
- Single byte, CLKS_PER_BIT=4, tx_data=8'hA5 -> tx_line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 10 bit_adv pulses; byte_done at cycle 40 after accept; tx_busy high for 40 cycles.
- Back-to-back 8'h00 then 8'hFF, tx_start held high -> exactly 1 idle-high cycle between the frames; second frame's data bits all 1; 2 byte_done pulses.
- tx_start pulsed with 8'h3C during the DATA state of a frame carrying 8'hC3 -> request ignored; the line carries only 8'hC3; tx_busy drops after one frame.
- UART_TX_PARITY_EN defined, tx_data=8'h07 (three ones) -> parity bit=1, frame is 11 bits, 11 bit_adv pulses. tx_data=8'h03 -> parity bit=0.
- Bit-counter hookup: bit_adv drives an 8-bit event counter; send 3 bytes -> counter reads 30 (33 with parity).
